// File: rtl/pc_seq_pkg.sv
// Shared state codes and default parameter values for the PC sequencer.
package pc_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_EXC    = 3'd5,
    ST_HOLD   = 3'd6
  } state_t;

  localparam int         DEF_PC_WIDTH    = 8;
  localparam int         DEF_ADDR_SHIFT  = 0;
  localparam logic [7:0] DEF_EXC_VECTOR  = 8'hF0;
  localparam int         DEF_MEM_TIMEOUT = 15;

endpackage

// File: rtl/pc_sequencer_mem_timeout_ctr.sv
// Counts cycles spent waiting in MEM; expired flags the last allowed wait cycle.
module mem_timeout_ctr
  import pc_seq_pkg::*;
#(
  parameter int LIMIT = DEF_MEM_TIMEOUT
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 8'd1;
    end
  end

  // count holds MEM cycles already elapsed, so the LIMIT-th cycle sees LIMIT-1
  assign expired = enable && (count == 8'(LIMIT - 1));

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/exec sequencer with MEM timeout and exception capture.
// Optional single-step parking in HOLD is enabled by defining PC_SEQ_SINGLE_STEP_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int          PC_WIDTH    = DEF_PC_WIDTH,
  parameter int          ADDR_SHIFT  = DEF_ADDR_SHIFT,
  parameter logic [31:0] EXC_VECTOR  = 32'(DEF_EXC_VECTOR),
  parameter int          MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic                SYS_clk,
  input  logic                SYS_rst,
  input  logic                SYS_load,
  input  logic [PC_WIDTH-1:0] SYS_pc_val,
  input  logic [31:0]         instr,
  input  logic                Branch,
  input  logic                Jump,
  input  logic                mem_access,
  input  logic                reg_write,
  input  logic                alu_zero,
  input  logic                exc_raise,
  input  logic                mem_ack,
  input  logic                step,
  output logic [PC_WIDTH-1:0] PC_current,
  output logic [31:0]         ir,
  output logic [2:0]          state,
  output logic                mem_req,
  output logic                reg_we,
  output logic [PC_WIDTH-1:0] EPC,
  output logic                EH_led,
  output logic [15:0]         retired
);

`ifdef PC_SEQ_SINGLE_STEP_EN
  localparam state_t RESUME_ST = ST_HOLD;
`else
  localparam state_t RESUME_ST = ST_FETCH;
`endif

  localparam logic [PC_WIDTH-1:0] EXC_PC = PC_WIDTH'(EXC_VECTOR);

  state_t              cur_state;
  logic                wb_write;
  logic                mem_expired;
  logic [31:0]         jump_off;
  logic [31:0]         branch_off;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] jump_target;
  logic [PC_WIDTH-1:0] branch_target;

  assign jump_off      = {{6{ir[25]}}, ir[25:0]} << ADDR_SHIFT;
  assign branch_off    = {{16{ir[15]}}, ir[15:0]} << ADDR_SHIFT;
  assign pc_inc        = PC_current + PC_WIDTH'(1);
  assign jump_target   = pc_inc + PC_WIDTH'(jump_off);
  assign branch_target = pc_inc + PC_WIDTH'(branch_off);
  assign state         = cur_state;

  mem_timeout_ctr #(
    .LIMIT(MEM_TIMEOUT)
  ) u_mem_timeout_ctr (
    .clk    (SYS_clk),
    .clear  (SYS_rst || SYS_load || (cur_state != ST_MEM)),
    .enable (cur_state == ST_MEM),
    .expired(mem_expired)
  );

  // reg_we and mem_req are registered: they are set on entry to WB/MEM and default low
  always_ff @(posedge SYS_clk) begin
    if (SYS_rst) begin
      cur_state  <= ST_FETCH;
      PC_current <= '0;
      ir         <= '0;
      EPC        <= '0;
      EH_led     <= 1'b0;
      retired    <= '0;
      mem_req    <= 1'b0;
      reg_we     <= 1'b0;
      wb_write   <= 1'b0;
    end else if (SYS_load) begin
      cur_state  <= ST_FETCH;
      PC_current <= SYS_pc_val;
      EH_led     <= 1'b0;
      mem_req    <= 1'b0;
      reg_we     <= 1'b0;
    end else begin
      reg_we  <= 1'b0;
      mem_req <= 1'b0;
      case (cur_state)
        ST_FETCH: begin
          ir        <= instr;
          cur_state <= ST_DECODE;
        end
        ST_DECODE: cur_state <= ST_EXEC;
        ST_EXEC: begin
          wb_write <= reg_write;
          if (exc_raise) begin
            cur_state <= ST_EXC;
          end else if (Jump) begin
            PC_current <= jump_target;
            retired    <= retired + 16'd1;
            cur_state  <= RESUME_ST;
          end else if (Branch) begin
            PC_current <= alu_zero ? branch_target : pc_inc;
            retired    <= retired + 16'd1;
            cur_state  <= RESUME_ST;
          end else if (mem_access) begin
            mem_req   <= 1'b1;
            cur_state <= ST_MEM;
          end else begin
            reg_we    <= reg_write;
            cur_state <= ST_WB;
          end
        end
        // an ack arriving on the last allowed cycle still completes the access
        ST_MEM: begin
          if (mem_ack) begin
            reg_we    <= wb_write;
            cur_state <= ST_WB;
          end else if (mem_expired) begin
            cur_state <= ST_EXC;
          end else begin
            mem_req <= 1'b1;
          end
        end
        ST_WB: begin
          PC_current <= pc_inc;
          retired    <= retired + 16'd1;
          cur_state  <= RESUME_ST;
        end
        ST_EXC: begin
          EPC        <= PC_current;
          PC_current <= EXC_PC;
          EH_led     <= 1'b1;
          cur_state  <= RESUME_ST;
        end
        ST_HOLD: begin
          if (step) cur_state <= ST_FETCH;
        end
        default: cur_state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected per-instruction results are queued at issue
// and compared when the FSM returns to FETCH (or HOLD with PC_SEQ_SINGLE_STEP_EN).
module tb_pc_sequencer;

  localparam int S_FETCH = 0;
  localparam int S_MEM   = 3;
  localparam int S_HOLD  = 6;

  typedef struct {
    string       tag;
    logic [31:0] instr;
    int          cycles;
    logic [7:0]  pc;
    logic [15:0] retired;
    logic        eh;
    logic [7:0]  epc;
    int          we_cnt;
    int          we_cycle;
    int          req_cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, load;
  logic [7:0]  pc_val;
  logic [31:0] instr;
  logic        branch, jump, mem_access, reg_write, alu_zero, exc_raise, mem_ack, step;
  logic [7:0]  pc_current, epc;
  logic [31:0] ir;
  logic [2:0]  state;
  logic        mem_req, reg_we, eh_led;
  logic [15:0] retired;

  exp_t        sb[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          cur_ack_delay;
  logic [7:0]  model_pc;
  logic [15:0] model_retired;
  logic        model_eh;
  logic [7:0]  model_epc;

  pc_sequencer dut (
    .SYS_clk   (clk),
    .SYS_rst   (rst),
    .SYS_load  (load),
    .SYS_pc_val(pc_val),
    .instr     (instr),
    .Branch    (branch),
    .Jump      (jump),
    .mem_access(mem_access),
    .reg_write (reg_write),
    .alu_zero  (alu_zero),
    .exc_raise (exc_raise),
    .mem_ack   (mem_ack),
    .step      (step),
    .PC_current(pc_current),
    .ir        (ir),
    .state     (state),
    .mem_req   (mem_req),
    .reg_we    (reg_we),
    .EPC       (epc),
    .EH_led    (eh_led),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearControls();
    branch = 0; jump = 0; mem_access = 0; reg_write = 0;
    alu_zero = 0; exc_raise = 0; mem_ack = 0; step = 0;
  endtask

  task automatic doLoad(input logic [7:0] val);
    load = 1; pc_val = val;
    tick();
    load = 0;
    model_pc = val;
    model_eh = 0;
    checkOutput("load_state", 32'(state), S_FETCH);
    checkOutput("load_pc", 32'(pc_current), 32'(val));
  endtask

  task automatic stepRelease(input string tag);
    checkOutput({tag, "_hold"}, 32'(state), S_HOLD);
    repeat (3) tick();
    checkOutput({tag, "_parked"}, 32'(state), S_HOLD);
    checkOutput({tag, "_parked_ret"}, 32'(retired), 32'(model_retired));
    step = 1;
    tick();
    step = 0;
    checkOutput({tag, "_resume"}, 32'(state), S_FETCH);
  endtask

  // Waits for the instruction to finish, then pops and compares its expected result
  task automatic collectResult();
    int   cycles = 0, we_cnt = 0, we_cycle = 0, req_cnt = 0, mem_idx = 0;
    exp_t e;
    do begin
      if (32'(state) == S_MEM) begin
        mem_ack = (mem_idx == cur_ack_delay);
        mem_idx++;
      end else begin
        mem_ack = 0;
      end
      cycles++;
      if (reg_we) begin
        we_cnt++;
        we_cycle = cycles;
      end
      if (mem_req) req_cnt++;
      tick();
    end while (32'(state) != S_FETCH && 32'(state) != S_HOLD && cycles < 60);
    mem_ack = 0;
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 32'(1), 32'(0));
      return;
    end
    e = sb.pop_front();
    checkOutput({e.tag, "_cycles"}, 32'(cycles), 32'(e.cycles));
    checkOutput({e.tag, "_ir"}, ir, e.instr);
    checkOutput({e.tag, "_pc"}, 32'(pc_current), 32'(e.pc));
    checkOutput({e.tag, "_retired"}, 32'(retired), 32'(e.retired));
    checkOutput({e.tag, "_eh"}, 32'(eh_led), 32'(e.eh));
    checkOutput({e.tag, "_epc"}, 32'(epc), 32'(e.epc));
    checkOutput({e.tag, "_we_cnt"}, 32'(we_cnt), 32'(e.we_cnt));
    checkOutput({e.tag, "_we_cycle"}, 32'(we_cycle), 32'(e.we_cycle));
    checkOutput({e.tag, "_req_cnt"}, 32'(req_cnt), 32'(e.req_cnt));
  endtask

  // Drives one instruction from FETCH, queues the model's expected outcome, then collects it
  task automatic applyStimulus(input string tag, input logic [31:0] i_word, input logic jmp,
                               input logic br, input logic zero, input logic mem,
                               input logic wr, input logic exc, input int ack_d);
    exp_t        e;
    logic [7:0]  pc1;
    logic [31:0] off;
    pc1 = model_pc + 8'd1;
    e.tag = tag; e.instr = i_word; e.we_cnt = 0; e.we_cycle = 0; e.req_cnt = 0;
    if (exc) begin
      e.cycles = 4;
      model_epc = model_pc; model_pc = 8'hF0; model_eh = 1;
    end else if (jmp) begin
      e.cycles = 3;
      off = {{6{i_word[25]}}, i_word[25:0]};
      model_pc = pc1 + off[7:0];
      model_retired++;
    end else if (br) begin
      e.cycles = 3;
      off = {{16{i_word[15]}}, i_word[15:0]};
      model_pc = zero ? pc1 + off[7:0] : pc1;
      model_retired++;
    end else if (mem && ack_d >= 0 && ack_d < 15) begin
      e.cycles = 5 + ack_d;
      e.req_cnt = ack_d + 1;
      e.we_cnt = wr ? 1 : 0;
      e.we_cycle = wr ? e.cycles : 0;
      model_pc = pc1; model_retired++;
    end else if (mem) begin
      e.cycles = 19;
      e.req_cnt = 15;
      model_epc = model_pc; model_pc = 8'hF0; model_eh = 1;
    end else begin
      e.cycles = 4;
      e.we_cnt = wr ? 1 : 0;
      e.we_cycle = wr ? 4 : 0;
      model_pc = pc1; model_retired++;
    end
    e.pc = model_pc; e.retired = model_retired; e.eh = model_eh; e.epc = model_epc;
    sb.push_back(e);
    instr = i_word; jump = jmp; branch = br; alu_zero = zero;
    mem_access = mem; reg_write = wr; exc_raise = exc; cur_ack_delay = ack_d;
    collectResult();
    clearControls();
`ifdef PC_SEQ_SINGLE_STEP_EN
    stepRelease(tag);
`endif
  endtask

  task automatic waitForMem(input string tag);
    int n = 0;
    while (32'(state) != S_MEM && n < 10) begin
      tick();
      n++;
    end
    checkOutput({tag, "_reached_mem"}, 32'(state), S_MEM);
  endtask

  initial begin
    logic [31:0] rnd;
    int          kind;
    clearControls();
    load = 0; pc_val = '0; instr = '0;
    rst = 1;
    repeat (2) tick();
    checkOutput("rst_state", 32'(state), S_FETCH);
    checkOutput("rst_pc", 32'(pc_current), 0);
    checkOutput("rst_ir", ir, 0);
    checkOutput("rst_epc", 32'(epc), 0);
    checkOutput("rst_eh", 32'(eh_led), 0);
    checkOutput("rst_retired", 32'(retired), 0);
    checkOutput("rst_mem_req", 32'(mem_req), 0);
    checkOutput("rst_reg_we", 32'(reg_we), 0);
    rst = 0;
    model_pc = 0; model_retired = 0; model_eh = 0; model_epc = 0;

    applyStimulus("alu_wr", 32'h0123_4567, 0, 0, 0, 0, 1, 0, -1);
    doLoad(8'h10);
    applyStimulus("br_taken", 32'h1000_FFFE, 0, 1, 1, 0, 0, 0, -1);
    doLoad(8'h10);
    applyStimulus("br_not_taken", 32'h1000_FFFE, 0, 1, 0, 0, 0, 0, -1);
    applyStimulus("jump_back", 32'h0BFF_FFFC, 1, 0, 0, 0, 0, 0, -1);
    applyStimulus("load_ack3", 32'h8C00_0004, 0, 0, 0, 1, 1, 0, 3);
    applyStimulus("load_ack0", 32'h8C00_0008, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus("store_ack14", 32'hAC00_0000, 0, 0, 0, 1, 0, 0, 14);
    applyStimulus("mem_timeout", 32'hAC00_000C, 0, 0, 0, 1, 0, 0, -1);
    applyStimulus("exc_raise", 32'h0000_000C, 0, 0, 0, 0, 1, 1, -1);

    // SYS_load in the middle of a MEM wait aborts it and clears the exception flag
    instr = 32'h8C00_0010; mem_access = 1; reg_write = 1;
    waitForMem("ld_mem");
    tick();
    load = 1; pc_val = 8'h42;
    tick();
    load = 0;
    clearControls();
    model_pc = 8'h42; model_eh = 0;
    checkOutput("ld_mem_state", 32'(state), S_FETCH);
    checkOutput("ld_mem_pc", 32'(pc_current), 32'h42);
    checkOutput("ld_mem_req", 32'(mem_req), 0);
    checkOutput("ld_mem_eh", 32'(eh_led), 0);
    checkOutput("ld_mem_retired", 32'(retired), 32'(model_retired));

    doLoad(8'hFF);
    applyStimulus("alu_wrap", 32'h0000_0020, 0, 0, 0, 0, 0, 0, -1);

    // reset during a pending access must abort it without a register write
    instr = 32'h8C00_0014; mem_access = 1; reg_write = 1;
    waitForMem("rst_mem");
    tick();
    rst = 1;
    tick();
    checkOutput("rst_mem_state", 32'(state), S_FETCH);
    checkOutput("rst_mem_we", 32'(reg_we), 0);
    checkOutput("rst_mem_req", 32'(mem_req), 0);
    checkOutput("rst_mem_pc", 32'(pc_current), 0);
    checkOutput("rst_mem_retired", 32'(retired), 0);
    rst = 0;
    clearControls();
    model_pc = 0; model_retired = 0; model_eh = 0; model_epc = 0;

    for (int i = 0; i < 6; i++) begin
      rnd = $urandom;
      kind = $urandom_range(0, 3);
      case (kind)
        0: applyStimulus($sformatf("rnd%0d_alu", i), rnd, 0, 0, 0, 0, rnd[0], 0, -1);
        1: applyStimulus($sformatf("rnd%0d_br", i), rnd, 0, 1, rnd[1], 0, 0, 0, -1);
        2: applyStimulus($sformatf("rnd%0d_jmp", i), rnd, 1, 0, 0, 0, 0, 0, -1);
        default: applyStimulus($sformatf("rnd%0d_mem", i), rnd, 0, 0, 0, 1, rnd[2], 0,
                               int'($urandom_range(0, 5)));
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL provide these parameters:
- PC_WIDTH, default 8: width of the PC and EPC in words.
- ADDR_SHIFT, default 0: left shift applied to branch/jump offsets.
- EXC_VECTOR, default 8'hF0: PC loaded on exception, truncated or zero-extended to PC_WIDTH.
- MEM_TIMEOUT, default 15: maximum MEM wait cycles, 1..255.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- SYS_clk  in  1  clock.
- SYS_rst  in  1  synchronous active-high reset.
- SYS_load  in  1  load PC from SYS_pc_val.
- SYS_pc_val  in  PC_WIDTH  PC load value.
- instr  in  32  instruction word from IMEM addressed by PC_current.
- Branch, Jump, mem_access, reg_write  in  1 each  decoded control; valid in EXEC.
- alu_zero  in  1  ALU zero flag; valid in EXEC.
- exc_raise  in  1  exception request; sampled in EXEC.
- mem_ack  in  1  DMEM completion.
- step  in  1  single-step pulse.
- PC_current  out  PC_WIDTH  current PC.
- ir  out  32  latched instruction.
- state  out  3  FSM state code.
- mem_req  out  1  DMEM request.
- reg_we  out  1  register-file write strobe.
- EPC  out  PC_WIDTH  exception PC.
- EH_led  out  1  sticky exception flag.
- retired  out  16  retired-instruction counter.

Function
REQ-004 The FSM SHALL use these state codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, EXC=5, HOLD=6.
REQ-005 In FETCH (1 cycle), the block SHALL latch instr into ir and go to DECODE.
REQ-006 DECODE SHALL last 1 cycle and go to EXEC.
REQ-007 EXEC transitions SHALL follow this priority:
- exc_raise -> EXC.
- Jump -> PC := PC+1 + (sext(ir[25:0]) << ADDR_SHIFT), go FETCH.
- Branch & alu_zero -> PC := PC+1 + (sext(ir[15:0]) << ADDR_SHIFT), go FETCH.
- Branch & !alu_zero -> PC := PC+1, go FETCH.
- mem_access -> MEM.
- Otherwise -> WB.
REQ-008 In MEM, the block SHALL hold mem_req=1 every cycle until mem_ack, then go to WB.
REQ-009 If MEM_TIMEOUT cycles elapse in MEM without mem_ack, the block SHALL drop mem_req and go to EXC.
REQ-010 In WB (1 cycle), the block SHALL drive reg_we=reg_write, set PC := PC+1, and go FETCH.
REQ-011 In EXC (1 cycle), the block SHALL set EPC := PC_current, PC := EXC_VECTOR, and EH_led := 1, then go FETCH.
REQ-012 All PC arithmetic SHALL be truncated modulo 2^PC_WIDTH; PC=all-ones plus 1 SHALL wrap to 0.
REQ-013 Instruction latency SHALL be: ALU op 4 cycles; jump/branch 3 cycles; load/store 5 cycles when mem_ack arrives in the first MEM cycle.
REQ-014 retired SHALL increment by 1 on each WB exit and each jump/branch exit, wrapping at 16'hFFFF; it SHALL NOT increment on EXC.
REQ-015 SYS_load=1 SHALL, from any state, set PC := SYS_pc_val, clear EH_led, deassert mem_req, and go FETCH next cycle; no write and no retire SHALL occur in that cycle.
REQ-016 SYS_rst SHALL take priority over SYS_load; SYS_load SHALL take priority over all FSM transitions.
REQ-017 reg_we SHALL be 0 in every state other than WB; mem_req SHALL be 0 in every state other than MEM.

Reset
REQ-018 On SYS_rst, at the next SYS_clk edge, the block SHALL set:
- state=FETCH, PC_current=0, ir=0, EPC=0, EH_led=0, retired=0, mem_req=0, reg_we=0.
- MEM timeout counter cleared.
REQ-019 A reset during MEM SHALL abort the access without asserting reg_we.

Configuration
REQ-020 With PC_SEQ_SINGLE_STEP_EN defined, every FETCH-bound exit from EXEC, WB, or EXC SHALL go to HOLD instead.
REQ-021 The block SHALL leave HOLD for FETCH on the cycle after step=1 is sampled, and SYS_load SHALL also exit HOLD.
REQ-022 With PC_SEQ_SINGLE_STEP_EN undefined, HOLD SHALL be unreachable and step SHALL be ignored.

Structure
REQ-023 Package pc_seq_pkg SHALL hold the state code constants, the 3-bit state width, and the default parameter values.
REQ-024 The MEM wait/timeout counter SHALL be a sub-module named mem_timeout_ctr, with inputs clear and enable and output expired.

Verification
REQ-025 The bench SHALL cover these scenarios:
- Reset, then ALU op with reg_write=1: reg_we=1 for exactly one cycle at cycle 4; PC_current 0->1; retired=1.
- Branch with alu_zero=1 and ir[15:0]=16'hFFFE at PC=8'h10: PC=8'h0F after 3 cycles; Branch with alu_zero=0: PC=8'h11.
- Load with mem_ack delayed 3 cycles: mem_req high for 4 cycles, then WB; with no ack: EXC after 15 cycles, EPC=PC, PC=8'hF0, EH_led=1.
- PC=8'hFF, ALU op: PC wraps to 8'h00.
- SYS_load=1 with SYS_pc_val=8'h42 during MEM: next cycle state=FETCH, PC=8'h42, mem_req=0, EH_led=0.
- With PC_SEQ_SINGLE_STEP_EN defined: FSM parks in HOLD after each instruction until step=1, and retired advances by one per step.
